spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/nileswan_spi_pkg.sv | 19 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_target.sv | 157 +++++++++++++++
 tb/tb_spi_target.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nileswan_spi_pkg.sv
// Shared types for the nileswan SPI target: FSM states,
// synchronized pin bundle and the default filler byte.
package nileswan_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } spi_state_e;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } pin_t;

   localparam logic [7:0] FILLER_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin,
// with rise/fall detection one register behind the chain.
module spi_pin_sync
   import nileswan_spi_pkg::*;
#(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output pin_t pin_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{INIT}};
         prev_q <= INIT;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign pin_o.level = sync_q[STAGES-1];
   assign pin_o.rise  = sync_q[STAGES-1] & ~prev_q;
   assign pin_o.fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode 0 target, MSB first, oversampled by the system
// clock, with a one-byte TX holding register and RX strobe.
module spi_target
   import nileswan_spi_pkg::*;
#(
   parameter logic [7:0] FILLER      = FILLER_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       SClk,
   input  logic       nSel,
   input  logic       SDi,
   output logic       SDo,
   output logic       SDoEnable,
   output logic [7:0] RxData,
   output logic       RxValid,
   input  logic [7:0] TxData,
   input  logic       TxLoad,
   output logic       TxReady,
   output logic [8:0] ByteCount,
   output logic       Selected,
   output logic       Overrun,
   output logic       Underrun,
   output logic       FrameEnd,
   input  logic       ClearFlags
);

   pin_t sclk_s, nsel_s, sdi_s;
   logic unused_pins;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk_i(Clk), .rst_ni(nReset), .pin_i(SClk), .pin_o(sclk_s)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_nsel (
      .clk_i(Clk), .rst_ni(nReset), .pin_i(nSel), .pin_o(nsel_s)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sdi (
      .clk_i(Clk), .rst_ni(nReset), .pin_i(SDi), .pin_o(sdi_s)
   );

   assign unused_pins = ^{sclk_s.level, sdi_s.rise, sdi_s.fall};

   spi_state_e state_q;
   logic [7:0] tx_sr_q, rx_sr_q, hold_q, rx_data_q;
   logic [2:0] bit_q;
   logic [8:0] byte_cnt_q;
   logic       tx_ready_q, rx_valid_q, reload_pend_q;
   logic       overrun_q, underrun_q, frame_end_q;
   logic       sdo_en_q, selected_q;

   logic       last_rise, do_reload;
   logic [7:0] rx_byte, reload_byte;

   assign last_rise   = (state_q == SHIFT) & sclk_s.rise
                      & (bit_q == 3'd7);
   assign rx_byte     = {rx_sr_q[6:0], sdi_s.level};
   assign reload_byte = tx_ready_q ? FILLER : hold_q;
   // Reload after the 8th rise happens on the following SClk fall
   assign do_reload   = ~nsel_s.rise & ((state_q == LOAD) |
                        ((state_q == SHIFT) & sclk_s.fall & reload_pend_q));

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q       <= IDLE;
         tx_sr_q       <= 8'hFF;
         rx_sr_q       <= '0;
         hold_q        <= '0;
         rx_data_q     <= '0;
         bit_q         <= '0;
         byte_cnt_q    <= '0;
         tx_ready_q    <= 1'b1;
         rx_valid_q    <= 1'b0;
         reload_pend_q <= 1'b0;
         overrun_q     <= 1'b0;
         underrun_q    <= 1'b0;
         frame_end_q   <= 1'b0;
         sdo_en_q      <= 1'b0;
         selected_q    <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_end_q <= 1'b0;
         selected_q  <= ~nsel_s.level;

         if (nsel_s.rise) begin
            state_q       <= IDLE;
            frame_end_q   <= 1'b1;
            sdo_en_q      <= 1'b0;
            reload_pend_q <= 1'b0;
            tx_sr_q       <= 8'hFF;
            if (last_rise) overrun_q <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (nsel_s.fall) begin
                     state_q       <= LOAD;
                     byte_cnt_q    <= '0;
                     bit_q         <= '0;
                     reload_pend_q <= 1'b0;
                     sdo_en_q      <= 1'b1;
                  end
               end
               LOAD: state_q <= SHIFT;
               SHIFT: begin
                  if (sclk_s.rise) begin
                     rx_sr_q <= rx_byte;
                     bit_q   <= bit_q + 3'd1;
                  end
                  if (last_rise) begin
                     rx_data_q     <= rx_byte;
                     rx_valid_q    <= 1'b1;
                     reload_pend_q <= 1'b1;
                     if (byte_cnt_q != 9'd511)
                        byte_cnt_q <= byte_cnt_q + 9'd1;
                  end
                  if (sclk_s.fall) begin
                     reload_pend_q <= 1'b0;
                     if (!reload_pend_q)
                        tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                  end
               end
               default: state_q <= IDLE;
            endcase
         end

         if (do_reload) begin
            tx_sr_q <= reload_byte;
            if (tx_ready_q) underrun_q <= 1'b1;
            else            tx_ready_q <= 1'b1;
         end

         // A same-cycle load misses the reload but lands afterwards
         if (TxLoad) begin
            hold_q     <= TxData;
            tx_ready_q <= 1'b0;
            if (!tx_ready_q) overrun_q <= 1'b1;
         end

         if (ClearFlags) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
         end
      end
   end

   assign SDo       = tx_sr_q[7];
   assign SDoEnable = sdo_en_q;
   assign RxData    = rx_data_q;
   assign RxValid   = rx_valid_q;
   assign TxReady   = tx_ready_q;
   assign ByteCount = byte_cnt_q;
   assign Selected  = selected_q;
   assign Overrun   = overrun_q;
   assign Underrun  = underrun_q;
   assign FrameEnd  = frame_end_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged SPI master at Clk/8 with
// an RX scoreboard queue checked on every RxValid strobe.
module tb_spi_target;

   logic       Clk = 1'b0;
   logic       nReset;
   logic       SClk, nSel, SDi;
   logic       SDo, SDoEnable;
   logic [7:0] RxData;
   logic       RxValid;
   logic [7:0] TxData;
   logic       TxLoad;
   logic       TxReady;
   logic [8:0] ByteCount;
   logic       Selected, Overrun, Underrun, FrameEnd;
   logic       ClearFlags;

   int errors = 0;
   int checks = 0;
   int fe_cnt = 0;
   int rxv_cnt = 0;
   logic [7:0] rxq[$];

   spi_target dut (
      .Clk(Clk), .nReset(nReset), .SClk(SClk), .nSel(nSel),
      .SDi(SDi), .SDo(SDo), .SDoEnable(SDoEnable),
      .RxData(RxData), .RxValid(RxValid), .TxData(TxData),
      .TxLoad(TxLoad), .TxReady(TxReady), .ByteCount(ByteCount),
      .Selected(Selected), .Overrun(Overrun), .Underrun(Underrun),
      .FrameEnd(FrameEnd), .ClearFlags(ClearFlags)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (nReset) begin
         if (FrameEnd) fe_cnt++;
         if (RxValid) begin
            rxv_cnt++;
            if (rxq.size() == 0) check("rx_extra", 1, 0);
            else check("rx", {24'd0, RxData}, {24'd0, rxq.pop_front()});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic tx_load(input logic [7:0] d, input logic clr);
      TxData = d;
      TxLoad = 1'b1;
      ClearFlags = clr;
      tick(1);
      TxLoad = 1'b0;
      ClearFlags = 1'b0;
   endtask

   task automatic clear_flags();
      ClearFlags = 1'b1;
      tick(1);
      ClearFlags = 1'b0;
   endtask

   task automatic spi_bits(input logic [7:0] mosi, input int nbits,
                           output logic [7:0] miso);
      miso = '0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         SDi = mosi[i];
         tick(4);
         miso[i] = SDo;
         SClk = 1'b1;
         tick(4);
         SClk = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] mosi, input logic [7:0] exp_tx);
      logic [7:0] m;
      rxq.push_back(mosi);
      spi_bits(mosi, 8, m);
      check("tx", {24'd0, m}, {24'd0, exp_tx});
   endtask

   task automatic select_dut();
      nSel = 1'b0;
      tick(8);
   endtask

   task automatic deselect_dut();
      nSel = 1'b1;
      tick(8);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_sdo"}, SDo, 1);
      check({pfx, "_sdoen"}, SDoEnable, 0);
      check({pfx, "_rxv"}, RxValid, 0);
      check({pfx, "_rxd"}, RxData, 0);
      check({pfx, "_txrdy"}, TxReady, 1);
      check({pfx, "_bcnt"}, ByteCount, 0);
      check({pfx, "_sel"}, Selected, 0);
      check({pfx, "_ovr"}, Overrun, 0);
      check({pfx, "_udr"}, Underrun, 0);
      check({pfx, "_fe"}, FrameEnd, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0, rv0;
      logic [7:0] m;
      nReset = 1'b0;
      SClk = 1'b0; nSel = 1'b1; SDi = 1'b1;
      TxData = '0; TxLoad = 1'b0; ClearFlags = 1'b0;
      tick(3);
      check_reset_vals("rst");
      nReset = 1'b1;
      tick(3);

      // Single byte: A5 out, 3C in
      tx_load(8'hA5, 1'b0);
      check("txrdy_load", TxReady, 0);
      select_dut();
      check("sel", Selected, 1);
      check("sdoen", SDoEnable, 1);
      fe0 = fe_cnt; rv0 = rxv_cnt;
      xfer(8'h3C, 8'hA5);
      tick(2);
      check("bcnt1", ByteCount, 1);
      deselect_dut();
      check("rxv1", rxv_cnt - rv0, 1);
      check("fe1", fe_cnt - fe0, 1);
      check("sdoen_off", SDoEnable, 0);

      // Three bytes, one load: filler for bytes 2 and 3
      clear_flags();
      tx_load(8'h5A, 1'b0);
      select_dut();
      check("udr_pre", Underrun, 0);
      fe0 = fe_cnt; rv0 = rxv_cnt;
      xfer(8'h11, 8'h5A);
      xfer(8'h22, 8'hFF);
      xfer(8'h33, 8'hFF);
      deselect_dut();
      check("udr3", Underrun, 1);
      check("bcnt3", ByteCount, 3);
      check("rxv3", rxv_cnt - rv0, 3);
      check("fe3", fe_cnt - fe0, 1);

      // Partial byte then a clean frame
      clear_flags();
      fe0 = fe_cnt; rv0 = rxv_cnt;
      select_dut();
      spi_bits(8'hE7, 5, m);
      deselect_dut();
      check("part_rxv", rxv_cnt - rv0, 0);
      check("part_fe", fe_cnt - fe0, 1);
      check("part_sel", Selected, 0);
      check("part_sdoen", SDoEnable, 0);
      tx_load(8'hC3, 1'b0);
      select_dut();
      xfer(8'h96, 8'hC3);
      deselect_dut();
      check("part_bcnt", ByteCount, 1);

      // Double load overrun; clear wins over same-cycle set
      clear_flags();
      tx_load(8'h11, 1'b0);
      tx_load(8'h77, 1'b0);
      check("ovr_set", Overrun, 1);
      select_dut();
      xfer(8'h0F, 8'h77);
      deselect_dut();
      check("ovr_hold", Overrun, 1);
      tx_load(8'h01, 1'b0);
      tx_load(8'h02, 1'b1);
      check("ovr_clr", Overrun, 0);
      check("udr_clr", Underrun, 0);

      // Reset mid-frame
      select_dut();
      xfer(8'hAA, 8'h02);
      spi_bits(8'hF0, 3, m);
      fe0 = fe_cnt;
      nReset = 1'b0;
      SClk = 1'b0; nSel = 1'b1; SDi = 1'b1;
      #1;
      check_reset_vals("mid");
      tick(3);
      nReset = 1'b1;
      tick(8);
      check("mid_fe", fe_cnt - fe0, 0);
      tx_load(8'h3C, 1'b0);
      select_dut();
      xfer(8'h5A, 8'h3C);
      deselect_dut();
      check("mid_bcnt", ByteCount, 1);

      // Long frame saturates ByteCount
      clear_flags();
      rv0 = rxv_cnt;
      select_dut();
      for (int i = 0; i < 512; i++) begin
         logic [7:0] b;
         b = i[7:0];
         xfer(b, 8'hFF);
      end
      deselect_dut();
      check("sat_bcnt", ByteCount, 511);
      check("sat_rxv", rxv_cnt - rv0, 512);
      check("rxq_empty", rxq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
